instr_loader: RTL and testbench

Program loader that writes the instruction memory from a byte stream. It is the write-side counterpart of the read-only, word-aligned, 32-bit-wide instruction store. It packs incoming bytes MSB-first into 32-bit instructions and issues one word write per instruction at consecutive word-aligned byte addresses. It holds the CPU while a load is in progress and reports completion, word count and overflow.

---
 rtl/instr_loader_pkg.sv | 21 ++
 rtl/instr_loader_byte_packer.sv | 67 ++++++
 rtl/instr_loader.sv | 160 ++++++++++++++++
 tb/tb_instr_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   state_t    : loader FSM states (IDLE, LOAD, DONE)
//   INSTR_BYTES: bytes per instruction word
//   wc_width() : width of the word counter for a given memory size
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int INSTR_BYTES = 4;

  // One extra bit so a completely full memory can still be counted.
  function automatic int wc_width(input int mem_size);
    return $clog2(mem_size / INSTR_BYTES) + 1;
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// instr_loader_byte_packer
// Assembles bytes MSB-first into a 32-bit instruction word.
// Each byte is placed directly into its final lane, so a word closed early
// by 'last' is already zero-padded in its low bytes.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   clear       : synchronous flush of any partial word
//   push        : accept 'data' this cycle
//   last        : pushed byte closes the word regardless of position
//   data [7:0]  : byte payload
//   word [31:0] : word including the byte being pushed (valid with word_ready)
//   word_ready  : push completes a word (4th byte or last)
//   empty       : next pushed byte is the first byte of a word
module instr_loader_byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic        last,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        empty
);

  logic [31:0] word_r;
  logic [1:0]  idx_r;
  logic [31:0] placed_s;

  // Position the incoming byte in the lane selected by the byte index.
  always_comb begin
    placed_s = 32'h0000_0000;
    case (idx_r)
      2'd0:    placed_s = {data, 24'h00_0000};
      2'd1:    placed_s = {8'h00, data, 16'h0000};
      2'd2:    placed_s = {16'h0000, data, 8'h00};
      2'd3:    placed_s = {24'h00_0000, data};
      default: placed_s = 32'h0000_0000;
    endcase
  end

  assign word       = word_r | placed_s;
  assign word_ready = push & (last | (idx_r == 2'd3));
  assign empty      = (idx_r == 2'd0);

  // Accumulate bytes; a completed word empties the packer for the next one.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_r <= 32'h0000_0000;
      idx_r  <= 2'd0;
    end else if (push) begin
      if (word_ready) begin
        word_r <= 32'h0000_0000;
        idx_r  <= 2'd0;
      end else begin
        word_r <= word;
        idx_r  <= idx_r + 2'd1;
      end
    end else begin
      word_r <= word_r;
      idx_r  <= idx_r;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader
// Loads the instruction memory from a byte stream: bytes are packed MSB-first
// into 32-bit words and written at consecutive word-aligned byte addresses
// starting at BASE_ADDR. The CPU is held while a load is in progress.
// Optional build macro LOADER_CHECKSUM_EN adds a 'checksum' output holding
// the XOR of every word written in the current load.
// Parameters: MEM_SIZE (bytes, power of two, > 4), BASE_ADDR (word aligned).
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start                 : pulse, begins a load from IDLE or DONE
//   in_valid/in_ready     : byte handshake; in_data payload, in_last marks end
//   wr_en/wr_addr/wr_data : one-cycle instruction-memory write
//   cpu_hold              : processor must stay stalled
//   busy                  : load in progress
//   done/error            : sticky completion / overflow flags
//   word_count            : words written in this load
//   checksum              : (LOADER_CHECKSUM_EN only) XOR of written words
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_SIZE  = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0] checksum,
`endif
  output logic [wc_width(MEM_SIZE)-1:0] word_count
);

  localparam int WCW = wc_width(MEM_SIZE);
  // Address register can reach MEM_SIZE itself once memory is full.
  localparam int AW  = $clog2(MEM_SIZE) + 1;
  localparam logic [AW-1:0] BASE_A    = AW'(BASE_ADDR);
  localparam logic [AW-1:0] LAST_A    = AW'(MEM_SIZE - INSTR_BYTES);
  localparam logic [AW-1:0] WORD_STEP = AW'(INSTR_BYTES);

  state_t          state_r;
  logic [AW-1:0]   addr_r;
  logic [AW-1:0]   wr_addr_r;
  logic            wr_en_r;
  logic [31:0]     wr_data_r;
  logic            done_r;
  logic            error_r;
  logic [WCW-1:0]  word_count_r;
  logic [31:0]     checksum_r;

  logic            hs_s;
  logic            ovf_s;
  logic            push_s;
  logic            start_s;
  logic            clear_s;
  logic [31:0]     word_s;
  logic            word_ready_s;
  logic            empty_s;

  assign in_ready = (state_r == LOAD);
  assign hs_s     = in_valid & in_ready;
  // Aligned address: addr + 3 >= MEM_SIZE is the same as addr > MEM_SIZE - 4.
  assign ovf_s    = hs_s & empty_s & (addr_r > LAST_A);
  assign push_s   = hs_s & ~ovf_s;
  assign start_s  = start & (state_r != LOAD);
  assign clear_s  = start_s | ovf_s;

  instr_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_s),
    .push       (push_s),
    .last       (in_last),
    .data       (in_data),
    .word       (word_s),
    .word_ready (word_ready_s),
    .empty      (empty_s)
  );

  // Loader FSM: owns addresses, sticky flags, counters and the write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= BASE_A;
      wr_addr_r    <= {AW{1'b0}};
      wr_en_r      <= 1'b0;
      wr_data_r    <= 32'h0000_0000;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      word_count_r <= {WCW{1'b0}};
      checksum_r   <= 32'h0000_0000;
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r      <= LOAD;
            addr_r       <= BASE_A;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            word_count_r <= {WCW{1'b0}};
            checksum_r   <= 32'h0000_0000;
          end else begin
            state_r <= state_r;
          end
        end
        LOAD: begin
          if (ovf_s) begin
            // Overflowing byte is consumed but never written.
            error_r <= 1'b1;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else if (push_s && word_ready_s) begin
            wr_en_r      <= 1'b1;
            wr_data_r    <= word_s;
            wr_addr_r    <= addr_r;
            addr_r       <= addr_r + WORD_STEP;
            word_count_r <= word_count_r + WCW'(1);
            checksum_r   <= checksum_r ^ word_s;
            if (in_last) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_r;
  assign wr_addr    = {{(64-AW){1'b0}}, wr_addr_r};
  assign wr_data    = wr_data_r;
  assign busy       = (state_r == LOAD);
  assign cpu_hold   = (state_r == LOAD) | wr_en_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = word_count_r;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = checksum_r;
`else
  logic unused_cks_s;
  assign unused_cks_s = ^checksum_r;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader
// Directed bench for instr_loader: a default instance (MEM_SIZE 1024) and a
// small instance (MEM_SIZE 16) share stimulus; writes of each are logged.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [7:0]  in_data;

  logic        in_ready0, wr_en0, cpu_hold0, busy0, done0, error0;
  logic [63:0] wr_addr0;
  logic [31:0] wr_data0;
  logic [8:0]  word_count0;
  logic        in_ready1, wr_en1, cpu_hold1, busy1, done1, error1;
  logic [63:0] wr_addr1;
  logic [31:0] wr_data1;
  logic [2:0]  word_count1;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cks0, cks1;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] a0 [64];
  logic [31:0] d0 [64];
  int          n0 = 0;
  logic [63:0] a1 [64];
  logic [31:0] d1 [64];
  int          n1 = 0;
  int          b0, b1;
  logic [7:0]  prog [8];

  always #5 clk = ~clk;

  instr_loader #(.MEM_SIZE(1024), .BASE_ADDR(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0),
`ifdef LOADER_CHECKSUM_EN
    .checksum(cks0),
`endif
    .word_count(word_count0)
  );

  instr_loader #(.MEM_SIZE(16), .BASE_ADDR(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1),
`ifdef LOADER_CHECKSUM_EN
    .checksum(cks1),
`endif
    .word_count(word_count1)
  );

  // Write logger: wr_en seen at the edge ends its one-cycle window.
  always @(posedge clk) begin
    if (wr_en0 && n0 < 64) begin
      a0[n0] <= wr_addr0;
      d0[n0] <= wr_data0;
      n0     <= n0 + 1;
    end
    if (wr_en1 && n1 < 64) begin
      a1[n1] <= wr_addr1;
      d1[n1] <= wr_data1;
      n1     <= n1 + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 8'h91; prog[1] = 8'h00; prog[2] = 8'h04; prog[3] = 8'h20;
    prog[4] = 8'hB4; prog[5] = 8'h00; prog[6] = 8'h00; prog[7] = 8'h40;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", {63'd0, in_ready0}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en0}, 64'd0);
    check("rst_busy", {63'd0, busy0}, 64'd0);
    check("rst_done", {63'd0, done0}, 64'd0);
    check("rst_error", {63'd0, error0}, 64'd0);
    check("rst_cpu_hold", {63'd0, cpu_hold0}, 64'd0);
    check("rst_word_count", {55'd0, word_count0}, 64'd0);
    check("rst_wr_addr", wr_addr0, 64'd0);
    check("rst_wr_data", {32'd0, wr_data0}, 64'd0);

    // Test 1: start together with a byte that must be ignored, then 8 bytes
    b0 = n0; b1 = n1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("t1_in_ready_after_start", {63'd0, in_ready0}, 64'd1);
    check("t1_busy", {63'd0, busy0}, 64'd1);
    check("t1_cpu_hold", {63'd0, cpu_hold0}, 64'd1);
    for (int i = 0; i < 8; i++) send(prog[i], (i == 7));
    idle();
    check("t1_final_wr_en", {63'd0, wr_en0}, 64'd1);
    check("t1_final_wr_addr", wr_addr0, 64'd4);
    check("t1_final_wr_data", {32'd0, wr_data0}, 64'hB400_0040);
    check("t1_done_with_write", {63'd0, done0}, 64'd1);
    check("t1_word_count", {55'd0, word_count0}, 64'd2);
    check("t1_hold_during_write", {63'd0, cpu_hold0}, 64'd1);
    check("t1_in_ready_done", {63'd0, in_ready0}, 64'd0);
    @(negedge clk);
    check("t1_hold_dropped", {63'd0, cpu_hold0}, 64'd0);
    check("t1_wr_en_single", {63'd0, wr_en0}, 64'd0);
    check("t1_done_sticky", {63'd0, done0}, 64'd1);
    check("t1_error", {63'd0, error0}, 64'd0);
    check("t1_num_writes", 64'(n0 - b0), 64'd2);
    check("t1_addr0", a0[b0], 64'd0);
    check("t1_data0", {32'd0, d0[b0]}, 64'h9100_0420);
    check("t1_addr1", a0[b0+1], 64'd4);
    check("t1_data1", {32'd0, d0[b0+1]}, 64'hB400_0040);
    check("t1_small_num_writes", 64'(n1 - b1), 64'd2);
    check("t1_small_data0", {32'd0, d1[b1]}, 64'h9100_0420);
`ifdef LOADER_CHECKSUM_EN
    check("t1_checksum", {32'd0, cks0}, 64'h2500_0460);
`endif

    // Test 2: partial last word is zero-padded
    b0 = n0;
    pulse_start();
`ifdef LOADER_CHECKSUM_EN
    check("t2_checksum_cleared", {32'd0, cks0}, 64'd0);
`endif
    check("t2_done_cleared", {63'd0, done0}, 64'd0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    send(8'h44, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    idle();
    @(negedge clk);
    check("t2_num_writes", 64'(n0 - b0), 64'd2);
    check("t2_data0", {32'd0, d0[b0]}, 64'h1122_3344);
    check("t2_addr1", a0[b0+1], 64'd4);
    check("t2_data1_padded", {32'd0, d0[b0+1]}, 64'hAABB_0000);
    check("t2_word_count", {55'd0, word_count0}, 64'd2);

    // Test 3: overflow on the 16-byte instance at byte 17
    b0 = n0; b1 = n1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 16) check("t3_no_error_yet", {63'd0, error1}, 64'd0);
      if (i == 17) begin
        check("t3_error", {63'd0, error1}, 64'd1);
        check("t3_done", {63'd0, done1}, 64'd1);
        check("t3_in_ready", {63'd0, in_ready1}, 64'd0);
      end
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      in_last  = (i == 19);
    end
    idle();
    @(negedge clk);
    check("t3_small_num_writes", 64'(n1 - b1), 64'd4);
    check("t3_small_addr3", a1[b1+3], 64'd12);
    check("t3_small_data3", {32'd0, d1[b1+3]}, 64'h0D0E_0F10);
    check("t3_small_word_count", {61'd0, word_count1}, 64'd4);
    check("t3_small_error_sticky", {63'd0, error1}, 64'd1);
    check("t3_big_num_writes", 64'(n0 - b0), 64'd5);
    check("t3_big_error", {63'd0, error0}, 64'd0);
    check("t3_big_addr4", a0[b0+4], 64'd16);

    // Test 4: in_valid toggling; cpu_hold window
    b0 = n0;
    check("t4_hold_before_start", {63'd0, cpu_hold0}, 64'd0);
    pulse_start();
    check("t4_hold_after_start", {63'd0, cpu_hold0}, 64'd1);
    for (int k = 0; k < 8; k++) begin
      send(prog[k], (k == 7));
      check("t4_hold_valid", {63'd0, cpu_hold0}, 64'd1);
      idle();
      check("t4_hold_gap", {63'd0, cpu_hold0}, 64'd1);
    end
    check("t4_final_wr_en", {63'd0, wr_en0}, 64'd1);
    @(negedge clk);
    check("t4_hold_dropped", {63'd0, cpu_hold0}, 64'd0);
    check("t4_num_writes", 64'(n0 - b0), 64'd2);
    check("t4_addr0", a0[b0], 64'd0);
    check("t4_data0", {32'd0, d0[b0]}, 64'h9100_0420);
    check("t4_addr1", a0[b0+1], 64'd4);
    check("t4_data1", {32'd0, d0[b0+1]}, 64'hB400_0040);

    // Test 5: reset mid-word, then reload from BASE_ADDR
    b0 = n0;
    pulse_start();
    send(8'hC0, 1'b0); send(8'hC1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t5_wr_en", {63'd0, wr_en0}, 64'd0);
    check("t5_busy", {63'd0, busy0}, 64'd0);
    check("t5_cpu_hold", {63'd0, cpu_hold0}, 64'd0);
    check("t5_done", {63'd0, done0}, 64'd0);
    check("t5_word_count", {55'd0, word_count0}, 64'd0);
    check("t5_in_ready", {63'd0, in_ready0}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check("t5_no_write", 64'(n0 - b0), 64'd0);
    pulse_start();
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
    idle();
    check("t5_reload_wr_en", {63'd0, wr_en0}, 64'd1);
    check("t5_reload_addr", wr_addr0, 64'd0);
    check("t5_reload_data", {32'd0, wr_data0}, 64'hDEAD_BEEF);
    check("t5_reload_count", {55'd0, word_count0}, 64'd1);
    check("t5_reload_done", {63'd0, done0}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
